// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready flow control, flush and bubble (RST_DATA) output.
// Define PIPE_STAGE_SKID_EN for the two-entry skid variant with a registered in_ready.
module pipe_stage_buf #(
  parameter int unsigned        DATA_W   = 160,
  parameter logic [DATA_W-1:0]  RST_DATA = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

`ifdef PIPE_STAGE_SKID_EN

  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [1:0]        r_occ;
  logic              r_in_ready;

  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic [1:0]        w_occ_nxt;
  logic              w_push;
  logic              w_pop;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = (r_occ != 2'd0) & out_ready;

  // next-state of the main/skid pair; flush empties both
  always_comb begin
    w_main_nxt = r_main;
    w_skid_nxt = r_skid;
    w_occ_nxt  = r_occ;
    if (flush) begin
      w_main_nxt = RST_DATA;
      w_skid_nxt = RST_DATA;
      w_occ_nxt  = 2'd0;
    end else begin
      case (r_occ)
        2'd0: begin
          if (w_push) begin
            w_main_nxt = in_data;
            w_occ_nxt  = 2'd1;
          end else begin
            w_occ_nxt  = 2'd0;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            w_main_nxt = in_data;
          end else if (w_push) begin
            w_skid_nxt = in_data;
            w_occ_nxt  = 2'd2;
          end else if (w_pop) begin
            w_main_nxt = RST_DATA;
            w_occ_nxt  = 2'd0;
          end else begin
            w_occ_nxt  = 2'd1;
          end
        end
        2'd2: begin
          if (w_pop) begin
            w_main_nxt = r_skid;
            w_skid_nxt = RST_DATA;
            w_occ_nxt  = 2'd1;
          end else begin
            w_occ_nxt  = 2'd2;
          end
        end
        default: begin
          w_main_nxt = RST_DATA;
          w_skid_nxt = RST_DATA;
          w_occ_nxt  = 2'd0;
        end
      endcase
    end
  end

  // in_ready is registered from the next occupancy, so out_ready never reaches it combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main     <= RST_DATA;
      r_skid     <= RST_DATA;
      r_occ      <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_occ      <= w_occ_nxt;
      r_in_ready <= (w_occ_nxt < 2'd2);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_occ != 2'd0);
  assign out_data  = r_main;
  assign occupancy = r_occ;

`else

  logic [DATA_W-1:0] r_main;
  logic              r_valid;
  logic              w_push;
  logic              w_pop;

  assign in_ready = ~r_valid | out_ready;
  assign w_push   = in_valid & in_ready;
  assign w_pop    = r_valid & out_ready;

  // single entry: push (with or without pop) replaces, pop alone leaves a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_main  <= RST_DATA;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_main  <= RST_DATA;
    end else if (w_push) begin
      r_valid <= 1'b1;
      r_main  <= in_data;
    end else if (w_pop) begin
      r_valid <= 1'b0;
      r_main  <= RST_DATA;
    end else begin
      r_valid <= r_valid;
      r_main  <= r_main;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_main;
  assign occupancy = {1'b0, r_valid};

`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf (DATA_W=32, RST_DATA=32'h100); runs with or without PIPE_STAGE_SKID_EN.
module tb_pipe_stage_buf;
  localparam int unsigned DW  = 32;
  localparam logic [31:0] RST = 32'h100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = 32'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data = 32'd0;

  pipe_stage_buf #(.DATA_W(DW), .RST_DATA(RST)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: at negedge the inputs for the coming edge are stable; compare then update the model.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold_prev = 1'b0;
    end else begin
      chk("occupancy", {30'd0, occupancy}, q.size());
      if (hold_prev) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", out_data, hold_data);
      end
      if (!out_valid) chk("bubble_data", out_data, RST);
      else if (q.size() == 0) chk("unexpected_out", {31'd0, out_valid}, 32'd0);
      else chk("front_data", out_data, q[0]);
      if (flush) begin
        q.delete();
        hold_prev = 1'b0;
      end else begin
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && in_ready) q.push_back(in_data);
        hold_prev = out_valid && !out_ready;
        hold_data = out_data;
      end
    end
  end

  initial begin
    step(); step();
    rst = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, RST);
    chk("rst_occ", {30'd0, occupancy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Stream A1..A5 with out_ready=1, then bubble
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA000_0000 + i;
      step();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_data", out_data, 32'hA000_0000 + i);
      chk("stream_occ", {30'd0, occupancy}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("bubble_valid", {31'd0, out_valid}, 32'd0);
    chk("bubble_out", out_data, RST);
    chk("bubble_occ", {30'd0, occupancy}, 32'd0);

    // Backpressure: A1, A2 with out_ready=0
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA000_0001;
    step();
`ifdef PIPE_STAGE_SKID_EN
    chk("bp_ready_a1", {31'd0, in_ready}, 32'd1);
`else
    chk("bp_ready_a1", {31'd0, in_ready}, 32'd0);
`endif
    in_data = 32'hA000_0002;
    step();
    in_valid = 1'b0;
    chk("bp_hold_data", out_data, 32'hA000_0001);
    chk("bp_ready_a2", {31'd0, in_ready}, 32'd0);
`ifdef PIPE_STAGE_SKID_EN
    chk("bp_occ", {30'd0, occupancy}, 32'd2);
`else
    chk("bp_occ", {30'd0, occupancy}, 32'd1);
`endif
    step();
    chk("bp_hold_again", out_data, 32'hA000_0001);
    out_ready = 1'b1;
    step();
`ifdef PIPE_STAGE_SKID_EN
    chk("skid_pop_data", out_data, 32'hA000_0002);
    chk("skid_pop_ready", {31'd0, in_ready}, 32'd1);
    step();
`endif
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush a full stage while B is offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hC000_0001;
    step();
    in_data = 32'hC000_0002;
    step();
    flush    = 1'b1;
    in_data  = 32'hBBBB_BBBB;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_data", out_data, RST);
    chk("flush_occ", {30'd0, occupancy}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step(); step();
    chk("flush_no_b", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-cycle with an entry held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hD000_0001;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data", out_data, RST);
    chk("arst_occ", {30'd0, occupancy}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst = 1'b0;

    // Random valid/ready backpressure
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(); step(); step();
    chk("drain_empty", q.size(), 32'd0);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
